// File: rtl/if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: FSM encodings, NOP word, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_pkg;

  // Fetch-stage control states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } if_state_t;

  // Instruction word used for pipeline bubbles
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Default PC loaded at reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / hold / bubble select.
// Latency: 1 cycle from load to outputs.
// Backpressure: hold when neither load nor bubble is asserted (stall).
// Ports: clk, rst_n (async active-low); load, bubble (controls);
//        in_instr, in_pc4 (fetched data); id_instr, id_pc4, id_valid (registered).
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             bubble,
  input  logic [WIDTH-1:0] in_instr,
  input  logic [WIDTH-1:0] in_pc4,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_pc4,
  output logic             id_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr <= WIDTH'(NOP_WORD);
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (bubble) begin
      id_instr <= WIDTH'(NOP_WORD);
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else if (load) begin
      id_instr <= in_instr;
      id_pc4   <= in_pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control, fetch counter, IF/ID register.
// Latency: imem_addr is combinational from PC; IF/ID outputs one cycle after fetch.
// Backpressure: stall holds PC and IF/ID; imem_ready=0 inserts a bubble; redirect wins.
// Ports: clk, rst_n; imem_addr/imem_data/imem_ready (instruction memory);
//        stall, redirect, redirect_pc, halt_req (control); id_instr, id_opcode,
//        id_pc4, id_valid (IF/ID); halted, fetch_count (status).
module if_stage
  import if_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  output logic [WIDTH-1:0] id_instr,
  output logic [5:0]       id_opcode,
  output logic [WIDTH-1:0] id_pc4,
  output logic             id_valid,
  output logic             halted,
  output logic [31:0]      fetch_count
);

  if_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_aligned;
  logic             ifid_load;
  logic             ifid_bubble;
  logic             count_inc;

  // Natural wrap of the adder gives the modulo-2^WIDTH behaviour
  assign pc_plus4         = pc_q + WIDTH'(4);
  // Targets are forced word-aligned
  assign redirect_aligned = redirect_pc & ~WIDTH'(2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_count <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (count_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    count_inc   = 1'b0;
    case (state_q)
      BOOT: begin
        // One idle cycle after reset; redirect is ignored here
        ifid_bubble = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d        = redirect_aligned;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          // hold everything
        end else if (imem_ready) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          count_inc = 1'b1;
        end else begin
          ifid_bubble = 1'b1;
        end
        // This cycle's fetch still completes before entering HALT
        if (halt_req) state_d = HALT;
      end
      HALT: begin
        ifid_bubble = 1'b1;
        if (redirect) pc_d = redirect_aligned;
        if (!halt_req) state_d = RUN;
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = BOOT;
      end
    endcase
  end

  if_id_reg #(.WIDTH(WIDTH)) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .bubble   (ifid_bubble),
    .in_instr (imem_data),
    .in_pc4   (pc_plus4),
    .id_instr (id_instr),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

  assign imem_addr = pc_q;
  assign id_opcode = id_instr[31:26];
  assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the fetch rules.
// Stimulus changes 1ns after each rising edge; outputs checked at the same point.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_boot, m_halt;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_data = mem_word(imem_addr);

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .id_instr    (id_instr),
    .id_opcode   (id_opcode),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_count = 32'h0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // Advance one clock; the model applies the fetch rules to the sampled inputs
  task automatic step();
    @(posedge clk);
    if (m_boot) begin
      model_bubble();
      m_boot = 1'b0;
    end else begin
      if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        model_bubble();
      end else if (m_halt) begin
        model_bubble();
      end else if (!stall) begin
        if (imem_ready) begin
          m_instr = mem_word(m_pc);
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
          m_count = m_count + 32'd1;
        end else begin
          model_bubble();
        end
      end
      m_halt = halt_req;
    end
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_instr !== 32'h0 || id_pc4 !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: got %h/%h want 0/0", id_instr, id_pc4); end
    n_cmp++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    #5 rst_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    logic [31:0] exp_addr [4];
    logic [31:0] exp_pc4  [4];
    exp_addr = '{32'h0, 32'h0, 32'h4, 32'h8};
    exp_pc4  = '{32'h0, 32'h0, 32'h4, 32'h8};
    // before the first edge: BOOT
    n_cmp++; if (imem_addr !== exp_addr[0]) begin n_fail++; $display("FAIL boot_addr: got %h want %h", imem_addr, exp_addr[0]); end
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++; if (imem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL boot_seq_addr[%0d]: got %h want %h", i, imem_addr, exp_addr[i]); end
      n_cmp++; if (id_pc4 !== exp_pc4[i]) begin n_fail++; $display("FAIL boot_seq_pc4[%0d]: got %h want %h", i, id_pc4, exp_pc4[i]); end
    end
    step();
    n_cmp++; if (id_pc4 !== 32'hC || imem_addr !== 32'hC) begin n_fail++; $display("FAIL boot_third: pc4 %h addr %h want c/c", id_pc4, imem_addr); end
    n_cmp++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL boot_count: got %0d want 3", fetch_count); end
    n_cmp++; if (id_instr !== mem_word(32'h8) || id_opcode !== mem_word(32'h8) >> 26) begin n_fail++; $display("FAIL boot_instr: got %h op %h want %h", id_instr, id_opcode, mem_word(32'h8)); end
  endtask

  task automatic test_stall();
    logic [31:0] s_instr, s_pc4, s_cnt;
    step(); // fetch 0xC, PC -> 0x10
    s_instr = id_instr; s_pc4 = id_pc4; s_cnt = fetch_count;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 10", i, imem_addr); end
      n_cmp++; if (id_instr !== s_instr || id_pc4 !== s_pc4 || fetch_count !== s_cnt) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %h/%h/%0d want %h/%h/%0d", i, id_instr, id_pc4, fetch_count, s_instr, s_pc4, s_cnt); end
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect_stall();
    logic [31:0] cnt;
    cnt = fetch_count;
    redirect = 1'b1; redirect_pc = 32'h0000_0043; stall = 1'b1;
    step();
    n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %h want 40", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0 || fetch_count !== cnt) begin n_fail++; $display("FAIL redir_bubble: valid %b cnt %0d want 0/%0d", id_valid, fetch_count, cnt); end
    idle_inputs();
  endtask

  task automatic test_not_ready();
    redirect = 1'b1; redirect_pc = 32'h22;
    step();
    idle_inputs();
    imem_ready = 1'b0;
    step();
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL nrdy_hold: valid %b addr %h want 0/20", id_valid, imem_addr); end
    imem_ready = 1'b1;
    step();
    n_cmp++; if (id_valid !== 1'b1 || id_pc4 !== 32'h24 || id_instr !== mem_word(32'h20)) begin
      n_fail++; $display("FAIL nrdy_fetch: valid %b pc4 %h instr %h want 1/24/%h", id_valid, id_pc4, id_instr, mem_word(32'h20)); end
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    logic        exp_h [5];
    exp_h = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    frozen = imem_addr + 32'd4; // the halt_req cycle still fetches
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 2) halt_req = 1'b0;
      n_cmp++; if (halted !== exp_h[i]) begin n_fail++; $display("FAIL halt_flag[%0d]: got %b want %b", i, halted, exp_h[i]); end
      n_cmp++; if (imem_addr !== (i < 4 ? frozen : frozen + 32'd4)) begin n_fail++; $display("FAIL halt_pc[%0d]: got %h", i, imem_addr); end
      if (i >= 1 && i <= 3) begin
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL halt_bubble[%0d]: got %b want 0", i, id_valid); end
      end
    end
    n_cmp++; if (id_valid !== 1'b1 || id_pc4 !== frozen + 32'd4) begin n_fail++; $display("FAIL halt_resume: valid %b pc4 %h want 1/%h", id_valid, id_pc4, frozen + 32'd4); end
  endtask

  task automatic test_random();
    logic h;
    h = 1'b0;
    for (int i = 0; i < 400; i++) begin
      imem_ready = ($urandom_range(9) < 8);
      stall      = ($urandom_range(9) < 2);
      redirect   = ($urandom_range(9) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      if ($urandom_range(9) == 0) h = ~h;
      halt_req = h;
      step();
      n_cmp++; if (imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, imem_addr, m_pc); end
      n_cmp++; if (id_instr !== m_instr || id_pc4 !== m_pc4 || id_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_ifid[%0d]: got %h/%h/%b want %h/%h/%b", i, id_instr, id_pc4, id_valid, m_instr, m_pc4, m_valid); end
      n_cmp++; if (fetch_count !== m_count) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, fetch_count, m_count); end
      n_cmp++; if (halted !== m_halt) begin n_fail++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, m_halt); end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [31:0] cnt;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target: got %h want fffffffc", imem_addr); end
    cnt = fetch_count;
    step();
    n_cmp++; if (imem_addr !== 32'h0 || id_pc4 !== 32'h0 || id_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_fetch: addr %h pc4 %h valid %b want 0/0/1", imem_addr, id_pc4, id_valid); end
    n_cmp++; if (fetch_count !== cnt + 32'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", fetch_count, cnt + 32'd1); end
  endtask

  task automatic test_async_reset();
    step();
    halt_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (imem_addr !== 32'h0 || fetch_count !== 32'h0) begin n_fail++; $display("FAIL arst_state: addr %h cnt %0d want 0/0", imem_addr, fetch_count); end
    n_cmp++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc4 !== 32'h0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL arst_outs: valid %b instr %h pc4 %h halted %b want all 0", id_valid, id_instr, id_pc4, halted); end
    #1 rst_n = 1'b1;
    step(); // BOOT ignores redirect
    n_cmp++; if (imem_addr !== 32'h0 || halted !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++; $display("FAIL arst_boot: addr %h halted %b valid %b want 0/0/0", imem_addr, halted, id_valid); end
    idle_inputs();
    step();
    n_cmp++; if (imem_addr !== m_pc || id_valid !== m_valid) begin n_fail++; $display("FAIL arst_run: addr %h valid %b want %h/%b", imem_addr, id_valid, m_pc, m_valid); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_redirect_stall();
    test_not_ready();
    test_halt();
    test_random();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
